// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter
// Arbitrates three burst requesters (data-read, data-store, ISA-read) onto a
// single DDR controller command port. dr and isa bursts use the read channel,
// st bursts use the write channel. One burst is in flight at a time and each
// grant walks IDLE -> BUSY -> DONE -> IDLE.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration
// (dr -> st -> isa -> dr); otherwise fixed priority dr > st > isa.
module ddr_burst_arbiter #(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int LEN_WIDTH      = 10,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                      mem_clk,
  input  logic                      rst,
  input  logic                      dr_req,
  input  logic                      st_req,
  input  logic                      isa_req,
  input  logic [DDR_ADDR_WIDTH-1:0] dr_addr,
  input  logic [DDR_ADDR_WIDTH-1:0] st_addr,
  input  logic [DDR_ADDR_WIDTH-1:0] isa_addr,
  input  logic [LEN_WIDTH-1:0]      dr_len,
  input  logic [LEN_WIDTH-1:0]      st_len,
  input  logic [LEN_WIDTH-1:0]      isa_len,
  output logic                      dr_done,
  output logic                      st_done,
  output logic                      isa_done,
  output logic [1:0]                owner,
  output logic                      busy,
  output logic                      rd_burst_req,
  output logic                      wr_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
  output logic [LEN_WIDTH-1:0]      rd_burst_len,
  output logic [LEN_WIDTH-1:0]      wr_burst_len,
  input  logic                      rd_burst_finish,
  input  logic                      wr_burst_finish,
  output logic                      timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_DR   = 2'd1;
  localparam logic [1:0] OWN_ST   = 2'd2;
  localparam logic [1:0] OWN_ISA  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0]          r_last;
`endif

  logic [1:0]                w_winner;
  logic [DDR_ADDR_WIDTH-1:0] w_winAddr;
  logic [LEN_WIDTH-1:0]      w_winLen;
  logic [LEN_WIDTH-1:0]      w_curLen;
  logic                      w_finish;
  logic                      w_lenZero;
  logic                      w_timeout;
  logic                      w_endBurst;

  // Pick the requester to grant next from the current request levels
  always_comb begin
    w_winner = OWN_NONE;
`ifdef ARB_ROUND_ROBIN_EN
    case (r_last)
      OWN_DR: begin
        if (st_req)       w_winner = OWN_ST;
        else if (isa_req) w_winner = OWN_ISA;
        else if (dr_req)  w_winner = OWN_DR;
      end
      OWN_ST: begin
        if (isa_req)      w_winner = OWN_ISA;
        else if (dr_req)  w_winner = OWN_DR;
        else if (st_req)  w_winner = OWN_ST;
      end
      default: begin
        if (dr_req)       w_winner = OWN_DR;
        else if (st_req)  w_winner = OWN_ST;
        else if (isa_req) w_winner = OWN_ISA;
      end
    endcase
`else
    if (dr_req)       w_winner = OWN_DR;
    else if (st_req)  w_winner = OWN_ST;
    else if (isa_req) w_winner = OWN_ISA;
`endif
  end

  // Route the winner's address/length and derive the end-of-burst conditions
  always_comb begin
    w_winAddr = dr_addr;
    w_winLen  = dr_len;
    case (w_winner)
      OWN_ST: begin
        w_winAddr = st_addr;
        w_winLen  = st_len;
      end
      OWN_ISA: begin
        w_winAddr = isa_addr;
        w_winLen  = isa_len;
      end
      default: begin
        w_winAddr = dr_addr;
        w_winLen  = dr_len;
      end
    endcase
    w_curLen   = (owner == OWN_ST) ? wr_burst_len    : rd_burst_len;
    w_finish   = (owner == OWN_ST) ? wr_burst_finish : rd_burst_finish;
    w_lenZero  = (w_curLen == '0);
    w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES));
    w_endBurst = w_lenZero | w_finish | w_timeout;
  end

  // Arbitration FSM; every output is a register updated here
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last        <= OWN_ISA;
`endif
      owner         <= OWN_NONE;
      busy          <= 1'b0;
      dr_done       <= 1'b0;
      st_done       <= 1'b0;
      isa_done      <= 1'b0;
      rd_burst_req  <= 1'b0;
      wr_burst_req  <= 1'b0;
      rd_burst_addr <= '0;
      wr_burst_addr <= '0;
      rd_burst_len  <= '0;
      wr_burst_len  <= '0;
      timeout_err   <= 1'b0;
    end else begin
      dr_done  <= 1'b0;
      st_done  <= 1'b0;
      isa_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_winner != OWN_NONE) begin
            owner   <= w_winner;
            busy    <= 1'b1;
            r_cnt   <= '0;
            r_state <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
            r_last  <= w_winner;
`endif
            if (w_winner == OWN_ST) begin
              wr_burst_addr <= w_winAddr;
              wr_burst_len  <= w_winLen;
            end else begin
              rd_burst_addr <= w_winAddr;
              rd_burst_len  <= w_winLen;
            end
          end
        end
        BUSY: begin
          if (w_endBurst) begin
            rd_burst_req <= 1'b0;
            wr_burst_req <= 1'b0;
            dr_done      <= (owner == OWN_DR);
            st_done      <= (owner == OWN_ST);
            isa_done     <= (owner == OWN_ISA);
            r_state      <= DONE;
            if (!w_lenZero && !w_finish && w_timeout) begin
              timeout_err <= 1'b1;
            end
          end else begin
            r_cnt        <= r_cnt + CNT_W'(1);
            rd_burst_req <= (owner != OWN_ST);
            wr_burst_req <= (owner == OWN_ST);
          end
        end
        DONE: begin
          owner   <= OWN_NONE;
          busy    <= 1'b0;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// tb_ddr_burst_arbiter
// Directed scoreboard bench: each scenario pushes the burst-request and
// done events it expects, and a monitor pops/compares them as they appear.
// Honours ARB_ROUND_ROBIN_EN for the simultaneous-request grant order.
module tb_ddr_burst_arbiter;

  localparam int AW = 28;
  localparam int LW = 10;
  localparam int TO = 8;

  logic          mem_clk = 1'b0;
  logic          rst;
  logic          dr_req, st_req, isa_req;
  logic [AW-1:0] dr_addr, st_addr, isa_addr;
  logic [LW-1:0] dr_len, st_len, isa_len;
  logic          dr_done, st_done, isa_done;
  logic [1:0]    owner;
  logic          busy;
  logic          rd_burst_req, wr_burst_req;
  logic [AW-1:0] rd_burst_addr, wr_burst_addr;
  logic [LW-1:0] rd_burst_len, wr_burst_len;
  logic          rd_burst_finish, wr_burst_finish;
  logic          timeout_err;

  typedef struct {
    int            kind;
    logic [1:0]    owner;
    logic [2:0]    doneVec;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          terr;
  } evt_t;

  evt_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic prevRd     = 1'b0;
  logic prevWr     = 1'b0;

  ddr_burst_arbiter #(
    .DDR_ADDR_WIDTH(AW),
    .LEN_WIDTH(LW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .mem_clk(mem_clk),
    .rst(rst),
    .dr_req(dr_req),
    .st_req(st_req),
    .isa_req(isa_req),
    .dr_addr(dr_addr),
    .st_addr(st_addr),
    .isa_addr(isa_addr),
    .dr_len(dr_len),
    .st_len(st_len),
    .isa_len(isa_len),
    .dr_done(dr_done),
    .st_done(st_done),
    .isa_done(isa_done),
    .owner(owner),
    .busy(busy),
    .rd_burst_req(rd_burst_req),
    .wr_burst_req(wr_burst_req),
    .rd_burst_addr(rd_burst_addr),
    .wr_burst_addr(wr_burst_addr),
    .rd_burst_len(rd_burst_len),
    .wr_burst_len(wr_burst_len),
    .rd_burst_finish(rd_burst_finish),
    .wr_burst_finish(wr_burst_finish),
    .timeout_err(timeout_err)
  );

  // Free-running memory clock
  always #5 mem_clk = ~mem_clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushReq(input logic wr, input logic [1:0] who, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    evt_t e;
    e.kind    = wr ? 2 : 1;
    e.owner   = who;
    e.doneVec = 3'b000;
    e.addr    = addr;
    e.len     = len;
    e.terr    = 1'b0;
    sb.push_back(e);
  endtask

  task automatic pushDone(input logic [1:0] who, input logic terr);
    evt_t e;
    e.kind  = 3;
    e.owner = who;
    e.addr  = '0;
    e.len   = '0;
    e.terr  = terr;
    case (who)
      2'd1:    e.doneVec = 3'b001;
      2'd2:    e.doneVec = 3'b010;
      default: e.doneVec = 3'b100;
    endcase
    sb.push_back(e);
  endtask

  task automatic monitorEvent(input int kind);
    evt_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL unexpectedEvent: got kind %0d, expected no event", kind);
    end else begin
      e = sb.pop_front();
      checkOutput("eventKind", kind, e.kind);
      if (kind == 3) begin
        checkOutput("doneVector", {isa_done, st_done, dr_done}, e.doneVec);
        checkOutput("doneTimeoutErr", timeout_err, e.terr);
      end else begin
        checkOutput("reqOwner", owner, e.owner);
        checkOutput("reqAddr", (kind == 2) ? wr_burst_addr : rd_burst_addr, e.addr);
        checkOutput("reqLen", (kind == 2) ? wr_burst_len : rd_burst_len, e.len);
        checkOutput("otherReqLow", (kind == 2) ? rd_burst_req : wr_burst_req, 0);
      end
    end
  endtask

  // Monitor: turn observed burst-request rises and done pulses into scoreboard pops
  initial begin
    forever begin
      @(negedge mem_clk);
      if (!rst) begin
        if (rd_burst_req && !prevRd) monitorEvent(1);
        if (wr_burst_req && !prevWr) monitorEvent(2);
        if (dr_done || st_done || isa_done) monitorEvent(3);
      end
      prevRd = rd_burst_req;
      prevWr = wr_burst_req;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [1:0] who, input logic req, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    case (who)
      2'd1: begin dr_req = req;  dr_addr = addr;  dr_len = len;  end
      2'd2: begin st_req = req;  st_addr = addr;  st_len = len;  end
      default: begin isa_req = req; isa_addr = addr; isa_len = len; end
    endcase
  endtask

  task automatic dropReq(input logic [1:0] who);
    case (who)
      2'd1:    dr_req  = 1'b0;
      2'd2:    st_req  = 1'b0;
      default: isa_req = 1'b0;
    endcase
  endtask

  task automatic waitOwner(input logic [1:0] who);
    for (int k = 0; k < 20; k++) begin
      @(negedge mem_clk);
      if (owner == who) break;
    end
    checkOutput("grantOwner", owner, who);
  endtask

  task automatic waitBurstReq(input logic wr);
    for (int k = 0; k < 20; k++) begin
      @(negedge mem_clk);
      if ((wr ? wr_burst_req : rd_burst_req) == 1'b1) break;
    end
    checkOutput("burstReqSeen", wr ? wr_burst_req : rd_burst_req, 1);
  endtask

  task automatic pulseFinish(input logic wr);
    if (wr) wr_burst_finish = 1'b1;
    else    rd_burst_finish = 1'b1;
    @(negedge mem_clk);
    wr_burst_finish = 1'b0;
    rd_burst_finish = 1'b0;
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 30; k++) begin
      @(negedge mem_clk);
      if (!busy) break;
    end
    checkOutput("returnIdle", busy, 0);
  endtask

  logic [AW-1:0] addrTab [1:3];
  logic [LW-1:0] lenTab  [1:3];
  logic [1:0]    seq     [0:3];
  int            nGrants;
  logic          holdReqs;
  int            reqCycles;

  // Directed scenarios
  initial begin
    rst = 1'b1;
    dr_req = 0; st_req = 0; isa_req = 0;
    dr_addr = '0; st_addr = '0; isa_addr = '0;
    dr_len = '0; st_len = '0; isa_len = '0;
    rd_burst_finish = 0; wr_burst_finish = 0;
    repeat (3) @(negedge mem_clk);
    checkOutput("rstOwner", owner, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstRdReq", rd_burst_req, 0);
    checkOutput("rstWrReq", wr_burst_req, 0);
    checkOutput("rstTimeoutErr", timeout_err, 0);
    checkOutput("rstDones", {isa_done, st_done, dr_done}, 0);
    checkOutput("rstRdAddr", rd_burst_addr, 0);
    checkOutput("rstWrLen", wr_burst_len, 0);
    rst = 1'b0;

    $display("[TB] single ISA request");
    pushReq(1'b0, 2'd3, 28'h0008000, 10'd72);
    pushDone(2'd3, 1'b0);
    applyStimulus(2'd3, 1'b1, 28'h0008000, 10'd72);
    waitOwner(2'd3);
    checkOutput("grantBusy", busy, 1);
    checkOutput("grantReqNotYet", rd_burst_req, 0);
    dropReq(2'd3);
    waitBurstReq(1'b0);
    pulseFinish(1'b0);
    waitIdle();
    checkOutput("ownerClearedAfterDone", owner, 0);

    $display("[TB] simultaneous requests");
    addrTab[1] = 28'h0000100; lenTab[1] = 10'd5;
    addrTab[2] = 28'h0000200; lenTab[2] = 10'd17;
    addrTab[3] = 28'h0000300; lenTab[3] = 10'd3;
`ifdef ARB_ROUND_ROBIN_EN
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd1;
    nGrants = 4; holdReqs = 1'b1;
`else
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0;
    nGrants = 3; holdReqs = 1'b0;
`endif
    for (int w = 1; w <= 3; w++) applyStimulus(2'(w), 1'b1, addrTab[w], lenTab[w]);
    for (int i = 0; i < nGrants; i++) begin
      pushReq(seq[i] == 2'd2, seq[i], addrTab[seq[i]], lenTab[seq[i]]);
      pushDone(seq[i], 1'b0);
      waitOwner(seq[i]);
      if (!holdReqs) dropReq(seq[i]);
      if (i == nGrants - 1) begin
        dr_req = 0; st_req = 0; isa_req = 0;
      end
      waitBurstReq(seq[i] == 2'd2);
      pulseFinish(seq[i] == 2'd2);
      waitIdle();
    end

    $display("[TB] wrong-type finish");
    pushReq(1'b1, 2'd2, 28'h0000400, 10'd9);
    pushDone(2'd2, 1'b0);
    applyStimulus(2'd2, 1'b1, 28'h0000400, 10'd9);
    waitOwner(2'd2);
    dropReq(2'd2);
    waitBurstReq(1'b1);
    pulseFinish(1'b0);
    checkOutput("wrongFinishBusy", busy, 1);
    checkOutput("wrongFinishWrReq", wr_burst_req, 1);
    checkOutput("wrongFinishOwner", owner, 2);
    pulseFinish(1'b1);
    waitIdle();

    $display("[TB] timeout with no finish");
    pushReq(1'b0, 2'd1, 28'h0000500, 10'd4);
    pushDone(2'd1, 1'b1);
    applyStimulus(2'd1, 1'b1, 28'h0000500, 10'd4);
    waitOwner(2'd1);
    dropReq(2'd1);
    waitBurstReq(1'b0);
    reqCycles = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge mem_clk);
      if (rd_burst_req) reqCycles++;
      else break;
    end
    checkOutput("timeoutReqCycles", reqCycles, TO);
    waitIdle();
    checkOutput("timeoutErrSticky", timeout_err, 1);
    rst = 1'b1;
    @(negedge mem_clk);
    checkOutput("timeoutErrClearedByRst", timeout_err, 0);
    rst = 1'b0;

    $display("[TB] finish coincident with timeout");
    pushReq(1'b1, 2'd2, 28'h0000600, 10'd6);
    pushDone(2'd2, 1'b0);
    applyStimulus(2'd2, 1'b1, 28'h0000600, 10'd6);
    waitOwner(2'd2);
    dropReq(2'd2);
    waitBurstReq(1'b1);
    reqCycles = 1;
    for (int k = 0; k < 20 && reqCycles < TO; k++) begin
      @(negedge mem_clk);
      if (wr_burst_req) reqCycles++;
      else break;
    end
    checkOutput("reqHeldToLastCycle", reqCycles, TO);
    pulseFinish(1'b1);
    waitIdle();
    checkOutput("finishBeatsTimeout", timeout_err, 0);

    $display("[TB] zero-length burst");
    pushDone(2'd1, 1'b0);
    applyStimulus(2'd1, 1'b1, 28'h0000700, 10'd0);
    waitOwner(2'd1);
    dropReq(2'd1);
    waitIdle();

    $display("[TB] reset mid-burst");
    pushReq(1'b0, 2'd3, 28'h0000800, 10'd20);
    applyStimulus(2'd3, 1'b1, 28'h0000800, 10'd20);
    waitOwner(2'd3);
    dropReq(2'd3);
    waitBurstReq(1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midRstRdReq", rd_burst_req, 0);
    checkOutput("midRstOwner", owner, 0);
    checkOutput("midRstBusy", busy, 0);
    repeat (2) @(negedge mem_clk);
    rst = 1'b0;
    repeat (6) @(negedge mem_clk);
    checkOutput("scoreboardLeftover", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
